// File: rtl/width_arb_in_fifo.sv
// First-word-fall-through input buffer ahead of the width converter.
// Occupancy comes from extra-bit pointers; almost_full and count depend only on registered state.
module width_arb_in_fifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        almost_full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Flush and reset swallow any same-cycle handshake; in_ready is not lowered for it.
    assign push = in_valid && !full && !flush && !rst;
    assign pop  = out_ready && !empty && !flush && !rst;

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out_data    = mem[rd_ptr[ADDR_W-1:0]];
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= PTR_W'(AF_THRESH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is never cleared; out_data is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_width_arb_in_fifo.sv
// Directed bench for width_arb_in_fifo: a negedge monitor keeps an occupancy model and a
// scoreboard queue of accepted words; the driver adds hand-computed spot checks.
module tb_width_arb_in_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [3:0]    count;
    logic          almost_full;

    int            n_vec = 0;
    int            n_err = 0;
    bit            check_en = 1'b0;
    int            mdl_count = 0;
    logic [DW-1:0] sb [$];

    width_arb_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: status vs. occupancy model, popped words vs. scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                bit push_m;
                bit pop_m;
                chk("status", {count, in_ready, out_valid, almost_full},
                    {4'(mdl_count), mdl_count != DEPTH, mdl_count != 0, mdl_count >= AF});
                if (rst || flush) begin
                    mdl_count = 0;
                    sb.delete();
                end else begin
                    pop_m  = (mdl_count != 0) && out_ready;
                    push_m = in_valid && (mdl_count != DEPTH);
                    if (pop_m) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL sb_underflow: pop with empty scoreboard, got 0x%0h at %0t",
                                     out_data, $time);
                        end else begin
                            chk("data", out_data, sb.pop_front());
                        end
                    end
                    if (push_m) sb.push_back(in_data);
                    mdl_count = mdl_count + int'(push_m) - int'(pop_m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    exp_a [5];
        logic [DW-1:0] sh;
        exp_a = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2};

        // reset then idle
        cyc();
        cyc();
        rst = 1'b0;
        check_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_status", {count, out_valid, in_ready, almost_full}, {4'd0, 1'b0, 1'b1, 1'b0});
        end

        // fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            cyc();
            chk("fill_count", count, i);
            chk("fill_af", almost_full, i >= 6);
        end
        chk("full_in_ready", in_ready, 0);
        in_data = 10'h3FF;
        cyc();
        cyc();
        chk("held_count", count, 8);
        in_valid = 1'b0;

        // drain in order
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", out_data, i);
            cyc();
        end
        chk("drained_valid", out_valid, 0);
        chk("drained_count", count, 0);
        out_ready = 1'b0;

        // steady push+pop at occupancy 3 across several pointer wraps
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(10'h100 + i);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 3; i < 23; i++) begin
            in_data = DW'(10'h100 + i);
            chk("conc_head", out_data, 10'h100 + i - 3);
            cyc();
            chk("conc_count", count, 3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("conc_drained", count, 0);
        out_ready = 1'b0;

        // converter hookup: 10-bit words serialised as five 2-bit chunks
        in_valid = 1'b1;
        in_data = 10'h2B4;
        cyc();
        in_data = 10'h155;
        cyc();
        in_valid = 1'b0;
        chk("conv_first", out_data, 10'h2B4);
        sh = out_data;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("conv_chunk_a", sh[2*k +: 2], exp_a[k]);
            chk("conv_hold", {out_valid, out_data}, {1'b1, 10'h155});
            cyc();
        end
        sh = out_data;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("conv_chunk_b", sh[2*k +: 2], 2'd1);
            cyc();
        end
        chk("conv_empty", count, 0);

        // flush, then reset, mid-burst with a colliding push
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                in_data = DW'(10'h040 + 16 * r + i);
                cyc();
            end
            chk("pre_clear_count", count, 5);
            in_data = 10'h0AA;
            if (r == 0) flush = 1'b1;
            else        rst   = 1'b1;
            cyc();
            flush = 1'b0;
            rst   = 1'b0;
            in_valid = 1'b0;
            chk("clear_state", {count, out_valid}, {4'd0, 1'b0});
            in_valid = 1'b1;
            in_data = 10'h011;
            cyc();
            in_data = 10'h022;
            cyc();
            in_valid = 1'b0;
            chk("post_clear_head", out_data, 10'h011);
            out_ready = 1'b1;
            cyc();
            cyc();
            cyc();
            out_ready = 1'b0;
            chk("post_clear_empty", count, 0);
        end

        cyc();
        check_en = 1'b0;
        chk("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
